// File: rtl/lap_stopwatch_pkg.sv
// Shared definitions for lap_stopwatch: digit limits, segment and anode patterns,
// the packed time record and the control/digit-select enums.
package lap_stopwatch_pkg;

  localparam logic [3:0] LIM_TENTHS   = 4'd9;
  localparam logic [3:0] LIM_SEC_ONES = 4'd9;
  localparam logic [3:0] LIM_SEC_TENS = 4'd5;
  localparam logic [3:0] LIM_MIN      = 4'd9;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [3:0] AN_TENTHS   = 4'b1110;
  localparam logic [3:0] AN_SEC_ONES = 4'b1101;
  localparam logic [3:0] AN_SEC_TENS = 4'b1011;
  localparam logic [3:0] AN_MIN      = 4'b0111;
  localparam logic [3:0] AN_BLANK    = 4'b1111;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] secTens;
    logic [3:0] secOnes;
    logic [3:0] tenths;
  } time_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_TENTHS   = 2'd0,
    SEL_SEC_ONES = 2'd1,
    SEL_SEC_TENS = 2'd2,
    SEL_MIN      = 2'd3
  } digit_sel_e;

  function automatic logic [3:0] clampDigit(input logic [3:0] value, input logic [3:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/lap_stopwatch_sseg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_sseg
  import lap_stopwatch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/lap_stopwatch.sv
// M:SS.t stopwatch (up count or countdown from preset) with lap hold, driving a muxed
// active-low 4-digit display. Define LAP_STOPWATCH_BLINK_EN to blink the display while done.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 5000000,
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned WRAP         = 1,
  parameter int unsigned BLINK_BITS   = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        mode_down,
  input  logic        load,
  input  logic [15:0] preset,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic [3:0]  an,
  output logic        running,
  output logic        done
);

  localparam int unsigned      PRE_W     = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam time_t            TIME_ZERO = time_t'(16'h0000);
  localparam time_t            TIME_ONE  = time_t'(16'h0001);
  localparam time_t            TIME_MAX  = time_t'(16'h9599);

  if (TICK_DIV < 2 || TICK_DIV > 16777216 || REFRESH_BITS < 2 || BLINK_BITS < 1) begin : g_badParam
    $error("lap_stopwatch: parameter out of range");
  end

  state_e                  r_state;
  state_e                  w_stateNext;
  logic [PRE_W-1:0]        r_prescale;
  time_t                   r_digits;
  time_t                   r_snapshot;
  logic                    r_lapHold;
  logic [REFRESH_BITS-1:0] r_refresh;

  logic       w_tick;
  logic       w_satHold;
  logic       w_reachDone;
  logic       w_startBlocked;
  logic       w_blank;
  time_t      w_incDigits;
  time_t      w_decDigits;
  time_t      w_presetDigits;
  time_t      w_shown;
  digit_sel_e w_sel;
  logic [3:0] w_digit;
  logic [6:0] w_seg;

  assign w_tick         = (r_state == ST_RUN) && (r_prescale == PRE_LAST);
  assign w_satHold      = (WRAP == 0) && (r_digits == TIME_MAX);
  assign w_reachDone    = mode_down ? (r_digits == TIME_ONE) : w_satHold;
  assign w_startBlocked = mode_down && (r_digits == TIME_ZERO);

  assign w_presetDigits.min     = clampDigit(preset[15:12], LIM_MIN);
  assign w_presetDigits.secTens = clampDigit(preset[11:8],  LIM_SEC_TENS);
  assign w_presetDigits.secOnes = clampDigit(preset[7:4],   LIM_SEC_ONES);
  assign w_presetDigits.tenths  = clampDigit(preset[3:0],   LIM_TENTHS);

  // Ripple-carry increment: each digit wraps at its limit and carries into the next
  always_comb begin
    w_incDigits = r_digits;
    if (r_digits.tenths >= LIM_TENTHS) begin
      w_incDigits.tenths = 4'd0;
      if (r_digits.secOnes >= LIM_SEC_ONES) begin
        w_incDigits.secOnes = 4'd0;
        if (r_digits.secTens >= LIM_SEC_TENS) begin
          w_incDigits.secTens = 4'd0;
          w_incDigits.min     = (r_digits.min >= LIM_MIN) ? 4'd0 : r_digits.min + 4'd1;
        end else begin
          w_incDigits.secTens = r_digits.secTens + 4'd1;
        end
      end else begin
        w_incDigits.secOnes = r_digits.secOnes + 4'd1;
      end
    end else begin
      w_incDigits.tenths = r_digits.tenths + 4'd1;
    end
  end

  always_comb begin
    w_decDigits = r_digits;
    if (r_digits.tenths == 4'd0) begin
      w_decDigits.tenths = LIM_TENTHS;
      if (r_digits.secOnes == 4'd0) begin
        w_decDigits.secOnes = LIM_SEC_ONES;
        if (r_digits.secTens == 4'd0) begin
          w_decDigits.secTens = LIM_SEC_TENS;
          w_decDigits.min     = (r_digits.min == 4'd0) ? LIM_MIN : r_digits.min - 4'd1;
        end else begin
          w_decDigits.secTens = r_digits.secTens - 4'd1;
        end
      end else begin
        w_decDigits.secOnes = r_digits.secOnes - 4'd1;
      end
    end else begin
      w_decDigits.tenths = r_digits.tenths - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A start_stop out of DONE only acknowledges the flag; it never restarts the count
  always_comb begin
    w_stateNext = r_state;
    if (clear || load) begin
      w_stateNext = ST_IDLE;
    end else if (start_stop) begin
      case (r_state)
        ST_IDLE: w_stateNext = w_startBlocked ? ST_IDLE : ST_RUN;
        ST_RUN:  w_stateNext = ST_IDLE;
        ST_DONE: w_stateNext = ST_IDLE;
        default: w_stateNext = ST_IDLE;
      endcase
    end else if (w_tick && w_reachDone) begin
      w_stateNext = ST_DONE;
    end
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    case (r_state)
      ST_RUN:  running = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
    end else if (clear || load) begin
      r_prescale <= '0;
    end else if (!start_stop && r_state == ST_RUN) begin
      r_prescale <= w_tick ? '0 : r_prescale + PRE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digits <= TIME_ZERO;
    end else if (clear) begin
      r_digits <= TIME_ZERO;
    end else if (load) begin
      r_digits <= w_presetDigits;
    end else if (!start_stop && w_tick) begin
      if (mode_down) begin
        r_digits <= w_decDigits;
      end else if (!w_satHold) begin
        r_digits <= w_incDigits;
      end
    end
  end

  // Snapshot uses the registered digits, so a coincident tick is not yet visible
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lapHold  <= 1'b0;
      r_snapshot <= TIME_ZERO;
    end else if (clear) begin
      r_lapHold <= 1'b0;
    end else if (lap) begin
      r_lapHold <= !r_lapHold;
      if (!r_lapHold) begin
        r_snapshot <= r_digits;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
    end
  end

`ifdef LAP_STOPWATCH_BLINK_EN
  logic [BLINK_BITS-1:0] r_blink;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + BLINK_BITS'(1);
    end
  end

  assign w_blank = (r_state == ST_DONE) && r_blink[BLINK_BITS-1];
`else
  assign w_blank = 1'b0;
`endif

  assign w_shown = r_lapHold ? r_snapshot : r_digits;
  assign w_sel   = digit_sel_e'(r_refresh[REFRESH_BITS-1 -: 2]);

  // The decimal point sits after the seconds digit and after the minute digit
  always_comb begin
    w_digit = w_shown.tenths;
    an      = AN_TENTHS;
    dp      = 1'b1;
    case (w_sel)
      SEL_TENTHS: begin
        w_digit = w_shown.tenths;
        an      = AN_TENTHS;
        dp      = 1'b1;
      end
      SEL_SEC_ONES: begin
        w_digit = w_shown.secOnes;
        an      = AN_SEC_ONES;
        dp      = 1'b0;
      end
      SEL_SEC_TENS: begin
        w_digit = w_shown.secTens;
        an      = AN_SEC_TENS;
        dp      = 1'b1;
      end
      SEL_MIN: begin
        w_digit = w_shown.min;
        an      = AN_MIN;
        dp      = 1'b0;
      end
      default: ;
    endcase
    if (w_blank) begin
      an = AN_BLANK;
      dp = 1'b1;
    end
  end

  bcd_to_sseg u_decoder (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  assign {g, f, e, d, c, b, a} = w_seg;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: a saturating (WRAP=0) and a wrapping (WRAP=1) instance
// share stimulus; expected display words are queued as stimulus is driven and read back off the mux.
module tb_lap_stopwatch;

  localparam int TICK_DIV     = 4;
  localparam int REFRESH_BITS = 4;

  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [3:0] AN_TABLE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic       DP_TABLE [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};

  typedef enum int {PULSE_START, PULSE_CLEAR, PULSE_LAP, PULSE_LOAD} pulse_e;
  typedef struct {
    bit         inst;
    logic [15:0] value;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic        mode_down = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h0000;

  logic [6:0]  segSat, segWrap;
  logic        dpSat, dpWrap;
  logic [3:0]  anSat, anWrap;
  logic        runningSat, runningWrap;
  logic        doneSat, doneWrap;

  logic [3:0]  tbRefresh;
  exp_t        expQ[$];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) tbRefresh <= 4'd0;
    else       tbRefresh <= tbRefresh + 4'd1;
  end

  lap_stopwatch #(.TICK_DIV(TICK_DIV), .REFRESH_BITS(REFRESH_BITS), .WRAP(0), .BLINK_BITS(25)) dutSat (
    .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .mode_down(mode_down), .load(load), .preset(preset),
    .a(segSat[0]), .b(segSat[1]), .c(segSat[2]), .d(segSat[3]), .e(segSat[4]), .f(segSat[5]), .g(segSat[6]),
    .dp(dpSat), .an(anSat), .running(runningSat), .done(doneSat)
  );

  lap_stopwatch #(.TICK_DIV(TICK_DIV), .REFRESH_BITS(REFRESH_BITS), .WRAP(1), .BLINK_BITS(25)) dutWrap (
    .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .mode_down(mode_down), .load(load), .preset(preset),
    .a(segWrap[0]), .b(segWrap[1]), .c(segWrap[2]), .d(segWrap[3]), .e(segWrap[4]), .f(segWrap[5]), .g(segWrap[6]),
    .dp(dpWrap), .an(anWrap), .running(runningWrap), .done(doneWrap)
  );

  function automatic logic [3:0] decodeSeg(input logic [6:0] seg);
    logic [3:0] digit = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (seg === SEG_TABLE[i]) digit = 4'(i);
    end
    return digit;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called #1 after a rising edge; the pulse is captured on the next edge
  task automatic applyStimulus(input pulse_e kind, input logic [15:0] value);
    preset = value;
    case (kind)
      PULSE_START: start_stop = 1'b1;
      PULSE_CLEAR: clear      = 1'b1;
      PULSE_LAP:   lap        = 1'b1;
      PULSE_LOAD:  load       = 1'b1;
      default: ;
    endcase
    waitCycles(1);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    load       = 1'b0;
  endtask

  task automatic expectDisplay(input bit inst, input logic [15:0] value);
    exp_t item;
    item.inst  = inst;
    item.value = value;
    expQ.push_back(item);
  endtask

  task automatic readDisplay(input string tag);
    exp_t        item;
    logic [15:0] shown;
    logic [6:0]  seg;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    item  = expQ.pop_front();
    shown = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      waitCycles(1);
      seg = item.inst ? segWrap : segSat;
      shown[4 * int'(tbRefresh[3:2]) +: 4] = decodeSeg(seg);
    end
    checkOutput(tag, shown, item.value);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(1);
    checkOutput("reset running", {15'd0, runningSat}, 16'd0);
    checkOutput("reset done", {15'd0, doneSat}, 16'd0);
    checkOutput("reset an/dp", {11'd0, anSat, dpSat}, {11'd0, 4'b1110, 1'b1});
    waitCycles(1);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      waitCycles(1);
      checkOutput($sformatf("refresh an/dp %0d", k), {11'd0, anSat, dpSat},
                  {11'd0, AN_TABLE[tbRefresh[3:2]], DP_TABLE[tbRefresh[3:2]]});
    end
    expectDisplay(0, 16'h0000);
    readDisplay("reset digits");

    applyStimulus(PULSE_START, 16'h0000);
    waitCycles(40);
    checkOutput("up running", {15'd0, runningSat}, 16'd1);
    applyStimulus(PULSE_START, 16'h0000);
    expectDisplay(0, 16'h0010);
    readDisplay("up 40 clocks");

    applyStimulus(PULSE_LOAD, 16'h9598);
    applyStimulus(PULSE_START, 16'h0000);
    waitCycles(8);
    checkOutput("sat done", {15'd0, doneSat}, 16'd1);
    checkOutput("sat running", {15'd0, runningSat}, 16'd0);
    checkOutput("wrap done", {15'd0, doneWrap}, 16'd0);
    checkOutput("wrap running", {15'd0, runningWrap}, 16'd1);
    applyStimulus(PULSE_START, 16'h0000);
    checkOutput("sat ack done", {15'd0, doneSat}, 16'd0);
    checkOutput("sat ack running", {15'd0, runningSat}, 16'd0);
    checkOutput("wrap stopped", {15'd0, runningWrap}, 16'd0);
    expectDisplay(0, 16'h9599);
    expectDisplay(1, 16'h0000);
    readDisplay("sat digits");
    readDisplay("wrap digits");

    mode_down = 1'b1;
    applyStimulus(PULSE_LOAD, 16'h0012);
    applyStimulus(PULSE_START, 16'h0000);
    waitCycles(44);
    checkOutput("down running at 0.1", {15'd0, runningSat}, 16'd1);
    checkOutput("down done at 0.1", {15'd0, doneSat}, 16'd0);
    waitCycles(4);
    checkOutput("down done", {15'd0, doneSat}, 16'd1);
    checkOutput("down running", {15'd0, runningSat}, 16'd0);
    checkOutput("down done wrap", {15'd0, doneWrap}, 16'd1);
    applyStimulus(PULSE_START, 16'h0000);
    checkOutput("down ack done", {15'd0, doneSat}, 16'd0);
    checkOutput("down ack running", {15'd0, runningSat}, 16'd0);
    applyStimulus(PULSE_START, 16'h0000);
    checkOutput("down start at zero", {15'd0, runningSat}, 16'd0);
    expectDisplay(0, 16'h0000);
    readDisplay("down digits");
    mode_down = 1'b0;

    applyStimulus(PULSE_LOAD, 16'hF7AC);
    expectDisplay(0, 16'h9599);
    expectDisplay(1, 16'h9599);
    readDisplay("clamp sat");
    readDisplay("clamp wrap");

    applyStimulus(PULSE_CLEAR, 16'h0000);
    applyStimulus(PULSE_START, 16'h0000);
    waitCycles(20);
    applyStimulus(PULSE_LAP, 16'h0000);
    waitCycles(79);
    applyStimulus(PULSE_START, 16'h0000);
    expectDisplay(0, 16'h0005);
    readDisplay("lap hold");
    applyStimulus(PULSE_LAP, 16'h0000);
    expectDisplay(0, 16'h0025);
    readDisplay("lap release");

    applyStimulus(PULSE_CLEAR, 16'h0000);
    applyStimulus(PULSE_START, 16'h0000);
    waitCycles(7);
    applyStimulus(PULSE_LAP, 16'h0000);
    applyStimulus(PULSE_START, 16'h0000);
    expectDisplay(0, 16'h0001);
    readDisplay("lap on tick");
    applyStimulus(PULSE_LAP, 16'h0000);
    expectDisplay(0, 16'h0002);
    readDisplay("lap on tick live");
    applyStimulus(PULSE_LAP, 16'h0000);
    applyStimulus(PULSE_CLEAR, 16'h0000);
    expectDisplay(0, 16'h0000);
    readDisplay("clear releases lap");

    applyStimulus(PULSE_START, 16'h0000);
    waitCycles(6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid reset an", {12'd0, anSat}, 16'h000E);
    checkOutput("mid reset seg", {9'd0, segSat}, {9'd0, 7'b1000000});
    checkOutput("mid reset running", {15'd0, runningSat}, 16'd0);
    waitCycles(1);
    reset = 1'b0;
    expectDisplay(0, 16'h0000);
    readDisplay("after reset digits");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
